des3_sig_collect: RTL
=====================

// Module: des3_sig_collect
// PURPOSE
//  Response compactor that sits directly downstream of the DES3 core in the on-chip test flow.
//  - Free-runs a phase counter aligned to the stimulus controller's 31-cycle vector period.
//  - Once per period, samples the core output and folds it into a 64-bit MISR signature.
//  - After NUM_VEC vectors, flags done and compares the signature against a golden value (pass/fail).
// PARAMETERS
//  PERIOD      31                     cycles per vector; must equal stimulus controller period (count 0..30)
//  SAMPLE_CYC  29                     phase value at which desOut is captured; 0 <= SAMPLE_CYC < PERIOD
//  NUM_VEC     16                     vectors to compact before done; 1..65535
//  MISR_POLY   64'h0000_0000_0000_001B  feedback taps XORed in when sig[63] shifts out
//  GOLDEN_SIG  64'h0                  expected final signature
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  en          in   1   level; captures only occur while high
//  desOut      in   64  DES3 core result
//  decrypt     in   1   mode of current vector; folded into bit 0 of captured data
//  sig         out  64  current MISR signature
//  vec_cnt     out  16  vectors captured so far
//  sample_stb  out  1   one-cycle pulse, high the cycle after each capture edge
//  done        out  1   sticky; NUM_VEC vectors compacted
//  pass        out  1   sticky; valid when done=1; 1 iff final sig == GOLDEN_SIG
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): phase=0, sig=0, vec_cnt=0, sample_stb=0, done=0, pass=0, state=IDLE.
//   Applies from any state, including mid-run.
//  Phase counter:
//   - Runs from reset regardless of state or en: phase <= (phase==PERIOD-1) ? 0 : phase+1.
//   - Tracks the stimulus controller, which is reset by the same rst.
//  Capture condition: edge where state==RUN && en && phase==SAMPLE_CYC.
//  Capture data: d = desOut ^ {63'b0, decrypt}.
//  MISR update: sig <= {sig[62:0],1'b0} ^ (sig[63] ? MISR_POLY : 64'h0) ^ d.
//  Capture edge also sets: vec_cnt <= vec_cnt+1; sample_stb <= 1.
//   On all other edges sample_stb <= 0.
//  FSM:
//   IDLE -> RUN on an edge where en=1. No capture on that edge, even if phase==SAMPLE_CYC.
//   RUN  -> DONE on the capture edge where vec_cnt+1 == NUM_VEC. That same edge registers:
//           done <= 1 and pass <= (misr_next == GOLDEN_SIG).
//   RUN, en=0: pause. Stay in RUN; sig and vec_cnt hold; phase keeps running.
//   DONE: sig, vec_cnt, done, pass all frozen; en ignored; exit only via rst.
//  Latency: 1 cycle from capture edge to sig, vec_cnt, done and pass.
//  Width rules:
//   - All MISR arithmetic is XOR on 64 bits; no carries.
//   - vec_cnt never exceeds NUM_VEC, so no wrap.
//   - phase is $clog2(PERIOD) bits.
//  desOut/decrypt changes on non-capture edges have no effect.
// TESTING
//  1. Assert rst 2 cycles, release -> sig=0, vec_cnt=0, done=0, pass=0, sample_stb=0;
//     first capture occurs at the edge with phase==29, i.e. 30 cycles after release.
//  2. NUM_VEC=2, en=1 from release; desOut=64'h8000_0000_0000_0000 at the 1st sample,
//     64'h0 at the 2nd, decrypt=0 -> sig=64'h8000_0000_0000_0000 after the 1st capture,
//     then sig=MISR_POLY (64'h1B); done=1; pass=(GOLDEN_SIG==64'h1B).
//  3. NUM_VEC=1, desOut=64'h0, decrypt=1 -> sig=64'h1, vec_cnt=1, done=1, single sample_stb pulse.
//  4. NUM_VEC=4; drop en for 40 cycles after the 1st capture -> no capture and no sample_stb
//     during the gap; capture resumes at the next phase==29 after en=1; done after 4 captures.
//  5. Toggle desOut every cycle except at phase==29 -> sig depends only on values present at phase==29.
//  6. rst mid-run (vec_cnt=3) and again in DONE -> all outputs 0, state IDLE,
//     phase restarts at 0; a full rerun reproduces the identical sig.

Source files
------------

// File: rtl/des3_sig_collect.sv
// Response compactor for the DES3 test flow. Samples the core output once per
// vector period, folds it into a 64-bit MISR and flags done/pass after NUM_VEC vectors.
//
// state | meaning
// IDLE  | waiting for en; phase counter already free-running
// RUN   | capturing one vector per period while en is high
// DONE  | signature frozen; left only through rst
module des3_sig_collect #(
    parameter int          PERIOD     = 31,
    parameter int          SAMPLE_CYC = 29,
    parameter int          NUM_VEC    = 16,
    parameter logic [63:0] MISR_POLY  = 64'h0000_0000_0000_001B,
    parameter logic [63:0] GOLDEN_SIG = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] desOut,
    input  logic        decrypt,
    output logic [63:0] sig,
    output logic [15:0] vec_cnt,
    output logic        sample_stb,
    output logic        done,
    output logic        pass
);

    localparam int            PW           = $clog2(PERIOD);
    localparam logic [PW-1:0] PHASE_LAST   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_CYC);
    localparam logic [15:0]   VEC_LAST     = 16'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic          capture;
    logic [63:0]   misr_next;

    assign capture   = (state == RUN) && en && (phase == PHASE_SAMPLE);
    // decrypt rides on bit 0 so an encrypt/decrypt mix-up changes the signature
    assign misr_next = {sig[62:0], 1'b0} ^ (sig[63] ? MISR_POLY : 64'h0)
                     ^ (desOut ^ {63'b0, decrypt});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            sig        <= '0;
            vec_cnt    <= '0;
            sample_stb <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            phase      <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            sample_stb <= capture;
            case (state)
                IDLE: begin
                    if (en)
                        state <= RUN;
                end
                RUN: begin
                    if (capture) begin
                        sig     <= misr_next;
                        vec_cnt <= vec_cnt + 16'd1;
                        if (vec_cnt == VEC_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (misr_next == GOLDEN_SIG);
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
